// File: rtl/debug_io_pkg.sv
// Shared types and constants for the front-panel debug controller.
package debug_io_pkg;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_IMEM = 2'd1,
    SRC_DMEM = 2'd2
  } src_e;

  localparam int NUM_BTN  = 5;
  localparam int BTN_C    = 0;
  localparam int BTN_U    = 1;
  localparam int BTN_D    = 2;
  localparam int BTN_L    = 3;
  localparam int BTN_R    = 4;

  localparam int SW_SCAN  = 12;
  localparam int SW_DEBUG = 15;
  localparam int ADDR_W   = 12;

  // Forward step through the source ring REG -> IMEM -> DMEM -> REG.
  function automatic src_e src_next(input src_e s);
    case (s)
      SRC_REG:  return SRC_IMEM;
      SRC_IMEM: return SRC_DMEM;
      SRC_DMEM: return SRC_REG;
      default:  return SRC_REG;
    endcase
  endfunction

  // Backward step through the source ring.
  function automatic src_e src_prev(input src_e s);
    case (s)
      SRC_REG:  return SRC_DMEM;
      SRC_IMEM: return SRC_REG;
      SRC_DMEM: return SRC_IMEM;
      default:  return SRC_REG;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one button.
// The synchroniser and accepted level come out of reset as "pressed", so a
// button held through reset must be released and pressed again to pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  // Next state: count consecutive samples that disagree with the accepted level.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d   = '0;
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: rtl/seven_segment_driver.sv
// Four-digit multiplexed hex display driver, active-low segments and anodes.
module seven_segment_driver #(
  parameter int REFRESH_W = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  logic [REFRESH_W-1:0] refresh_q, refresh_d;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic [1:0]           digit_idx;
  logic [3:0]           nibble;

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  assign digit_idx = refresh_q[REFRESH_W-1 -: 2];

  // Pick the active digit and its nibble from the refresh counter.
  always_comb begin
    refresh_d = refresh_q + REFRESH_W'(1);
    case (digit_idx)
      2'd0:    begin nibble = value[3:0];   an_d = 4'b1110; end
      2'd1:    begin nibble = value[7:4];   an_d = 4'b1101; end
      2'd2:    begin nibble = value[11:8];  an_d = 4'b1011; end
      2'd3:    begin nibble = value[15:12]; an_d = 4'b0111; end
      default: begin nibble = 4'h0;         an_d = 4'b1111; end
    endcase
    seg_d = hex_to_seg(nibble);
  end

  // Registered refresh counter and display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      refresh_q <= '0;
      seg_q     <= 7'b1111111;
      an_q      <= 4'b1111;
    end else begin
      refresh_q <= refresh_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: rtl/debug_io_controller.sv
// Basys3 front-panel debug controller: steppable debug address, source
// selection across register file / IMEM / DMEM, and timed auto-scan.
module debug_io_controller
  import debug_io_pkg::*;
#(
  parameter int DATA_W             = 8,
  parameter int D_ADDR_W           = 12,
  parameter int INST_W             = 16,
  parameter int I_ADDR_W           = 12,
  parameter int REG_COUNT          = 16,
  parameter int DEBOUNCE_CYCLES    = 100000,
  parameter int SCAN_PERIOD_CYCLES = 50000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [15:0]                  sw,
  input  logic [4:0]                   btn,
  output logic [15:0]                  led,
  output logic [6:0]                   seg,
  output logic [3:0]                   an,
  output logic                         debug_enable,
  output logic [$clog2(REG_COUNT)-1:0] reg_debug_addr,
  input  logic [DATA_W-1:0]            reg_debug_rdata,
  output logic [D_ADDR_W-1:0]          dmem_debug_addr,
  input  logic [DATA_W-1:0]            dmem_debug_rdata,
  output logic [I_ADDR_W-1:0]          imem_debug_addr,
  input  logic [INST_W-1:0]            imem_debug_rdata
);

  localparam int RA_W  = $clog2(REG_COUNT);
  localparam int TMR_W = $clog2(SCAN_PERIOD_CYCLES);

  localparam logic [ADDR_W-1:0] REG_MASK  = ADDR_W'(REG_COUNT - 1);
  localparam logic [ADDR_W-1:0] IMEM_MASK = ADDR_W'((1 << I_ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] DMEM_MASK = ADDR_W'((1 << D_ADDR_W) - 1);

  logic [15:0]       sw_meta_q, sw_meta_d;
  logic [15:0]       sw_sync_q, sw_sync_d;
  src_e              src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [15:0]       disp_q, disp_d;

  logic [NUM_BTN-1:0] btn_pulse;
  logic              scan_active;
  logic              any_pulse;
  logic              scan_tc;
  logic              scan_step;
  logic [ADDR_W-1:0] mask;
  logic              unused_sw;

  // All depths are powers of two, so "modulo depth" is a mask.
  function automatic logic [ADDR_W-1:0] depth_mask(input src_e s);
    case (s)
      SRC_REG:  return REG_MASK;
      SRC_IMEM: return IMEM_MASK;
      SRC_DMEM: return DMEM_MASK;
      default:  return REG_MASK;
    endcase
  endfunction

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw  (btn[i]),
      .btn_pulse(btn_pulse[i])
    );
  end

  assign scan_active = sw_sync_q[SW_SCAN] & sw_sync_q[SW_DEBUG];
  assign any_pulse   = |btn_pulse;
  assign unused_sw   = ^sw_sync_q[14:13];

  // Next-state for source, address, scan timer and display capture.
  always_comb begin
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;

    if (btn_pulse[BTN_R] && !btn_pulse[BTN_L]) begin
      src_d = src_next(src_q);
    end else if (btn_pulse[BTN_L] && !btn_pulse[BTN_R]) begin
      src_d = src_prev(src_q);
    end else begin
      src_d = src_q;
    end
    mask = depth_mask(src_d);

    // Timer restarts on any button activity so a manual step resets the period.
    scan_tc = (tmr_q == TMR_W'(SCAN_PERIOD_CYCLES - 1));
    if (!scan_active || any_pulse) begin
      tmr_d = '0;
    end else if (scan_tc) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    scan_step = scan_active && !any_pulse && scan_tc;

    // Source change reduces the address into the new depth in the same update.
    if (btn_pulse[BTN_C]) begin
      addr_d = sw_sync_q[ADDR_W-1:0] & mask;
    end else if (btn_pulse[BTN_U] && !btn_pulse[BTN_D]) begin
      addr_d = (addr_q + 12'd1) & mask;
    end else if (btn_pulse[BTN_D] && !btn_pulse[BTN_U]) begin
      addr_d = (addr_q - 12'd1) & mask;
    end else if (scan_step) begin
      addr_d = (addr_q + 12'd1) & mask;
    end else begin
      addr_d = addr_q & mask;
    end

    case (src_q)
      SRC_REG:  disp_d = 16'(reg_debug_rdata);
      SRC_IMEM: disp_d = 16'(imem_debug_rdata);
      SRC_DMEM: disp_d = 16'(dmem_debug_rdata);
      default:  disp_d = 16'h0000;
    endcase
  end

  // Controller state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
      src_q     <= SRC_REG;
      addr_q    <= 12'h000;
      tmr_q     <= '0;
      disp_q    <= 16'h0000;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      src_q     <= src_d;
      addr_q    <= addr_d;
      tmr_q     <= tmr_d;
      disp_q    <= disp_d;
    end
  end

  seven_segment_driver u_seven_seg (
    .clk    (clk),
    .reset_n(reset_n),
    .value  (disp_q),
    .seg    (seg),
    .an     (an)
  );

  assign debug_enable    = sw_sync_q[SW_DEBUG];
  assign reg_debug_addr  = addr_q[RA_W-1:0];
  assign imem_debug_addr = addr_q[I_ADDR_W-1:0];
  assign dmem_debug_addr = addr_q[D_ADDR_W-1:0];
  assign led             = {sw_sync_q[SW_DEBUG], scan_active, src_q, addr_q};

endmodule
